window_3x3_gen: RTL and testbench
=================================

# window_3x3_gen

Streaming 3x3 neighbourhood generator that produces the nine-pixel window consumed by the 3x3 convolution kernels. It accepts raster-order pixels, one per accepted cycle, and buffers two image rows in line buffers. For every input pixel at row ≥ 2 and column ≥ 2 it emits one registered window (p0..p8) under a valid/ready handshake. It sits between the pixel source (frame memory reader) and the combinational kernel stage.

## Interface
- IMG_W, 64, pixels per row (≥ 3)
- IMG_H, 64, rows per frame (≥ 3)
- PIX_W, 13, pixel width in bits; matches the kernel input width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block can accept in_pixel this cycle
- in_pixel  in  PIX_W  raster-order pixel
- out_valid  out  1  window valid
- out_ready  in  1  downstream accepts window
- p0..p8  out  PIX_W each  window; p0–p2 top row, p3–p5 middle row, p6–p8 bottom row; left to right within each row
- out_last  out  1  window is the final one of the frame
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

## Operation
- Accept = in_valid && in_ready. All state advances only on accept.
- Counters: col in 0..IMG_W-1 and row in 0..IMG_H-1, both on accept. col wraps to 0 and increments row; at (IMG_H-1, IMG_W-1) both wrap to 0.
- Line buffers:
  - lb0 delays the input by IMG_W accepts and yields row r-1 at column c.
  - lb1 delays lb0's output by IMG_W accepts and yields row r-2.
  - Both are read-before-write at address col.
- Window shift: on accept, every window row shifts left by one column. The new right column is {lb1_out, lb0_out, in_pixel} into {p2, p5, p8}.
- Pixel at (r,c) → window covering rows r-2..r and cols c-2..c; p8 is that pixel.
- FSM, two states:
  - S_FILL (reset state; row < 2): no windows are emitted. Transition to S_RUN on the accept with col=IMG_W-1 and row=1.
  - S_RUN: a window is emitted on each accept with col ≥ 2. Return to S_FILL on the accept of the last frame pixel.
- Window count per frame: (IMG_H-2)·(IMG_W-2), which is 3844 at the defaults.
- out_last = 1 on the window of pixel (IMG_H-1, IMG_W-1).
- frame_done asserts the cycle after that pixel is accepted, independent of out_ready.
- No arithmetic on pixel data; values pass through unchanged.

## Timing
- Latency: the window appears (out_valid=1) in the cycle after the accept of its p8 pixel.
- in_ready = !out_valid || out_ready, which gives a single-stage skid-free stall.
- out_valid next-state:
  - Set to 1 on an accept that emits a window.
  - Otherwise cleared to 0 when out_ready=1.
  - Otherwise held.
- While out_valid && !out_ready, p0..p8 and out_last are held stable.
- Simultaneous out_ready and a new emitting accept: the new window replaces the old one with no bubble, giving a throughput of 1 window per cycle.
- Reset values: out_valid=0, out_last=0, frame_done=0, p0..p8=0, in_ready=1, col=row=0, state=S_FILL. Line-buffer contents are not cleared; S_FILL masks them.
- Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- Back-to-back frames need no idle cycles. Stale line-buffer rows are masked by S_FILL.

## Configuration
- WINGEN_POS_OUT_EN defined: adds ports out_row and out_col (width $clog2(IMG_H) and $clog2(IMG_W)). They carry the centre coordinate of the window, (r-1, c-1), registered with p0..p8 and held under stall.
- Macro not defined: these ports and their registers are absent; all other behaviour is identical.

## Structure
- Package wingen_pkg holds:
  - default constants IMG_W_DEF, IMG_H_DEF, PIX_W_DEF
  - the state enum {S_FILL, S_RUN}
  - coordinate width functions
- One sub-module, line_buffer: a single-port read-before-write delay line of depth IMG_W and width PIX_W, with an enable input tied to accept. It is instantiated twice (lb0, lb1).

## Test plan
- Small image: IMG_W=IMG_H=4, pixel = 4r+c, continuous valid, out_ready=1 → exactly 4 windows. The first window appears the cycle after pixel 10 and is p0..p8 = 0,1,2,4,5,6,8,9,10. The last window is 5,6,7,9,10,11,13,14,15 with out_last=1.
- Full default frame, pixel = 64r+c → 3844 windows. The final window has p0=3965 and p8=4095, with out_last=1. frame_done pulses once.
- Backpressure: out_ready low for 5 cycles mid-row → in_ready low during the stall, window held bit-stable, and no window lost or duplicated against the reference model.
- Random in_valid gaps (50% duty), 4x4 ramp → same 4 windows as the continuous case, in order.
- rst asserted for one cycle after 100 accepted pixels → out_valid=0 next cycle. The next frame's first window follows its pixel index 2·IMG_W+2 and holds that frame's values only.
- Two back-to-back 64x64 frames with distinct ramps (frame 2 = frame 1 + 1000) → frame 2's first window is p0=1000 … p8=1130, with no frame-1 data.

Source files
------------

// File: rtl/window_3x3_gen_pkg.sv
// wingen_pkg: shared definitions for the 3x3 window generator.
//   - default geometry / pixel width constants
//   - state_t: fill/run state of the window FSM
//   - col_width / row_width: counter widths for a given image size
package wingen_pkg;

    localparam int IMG_W_DEF = 64;
    localparam int IMG_H_DEF = 64;
    localparam int PIX_W_DEF = 13;

    typedef enum logic {
        S_FILL = 1'b0,   // first two rows of a frame: no complete window yet
        S_RUN  = 1'b1    // rows 2..IMG_H-1: windows emitted from column 2 on
    } state_t;

    function automatic int col_width(input int img_w);
        return (img_w > 1) ? $clog2(img_w) : 1;
    endfunction

    function automatic int row_width(input int img_h);
        return (img_h > 1) ? $clog2(img_h) : 1;
    endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// window_3x3_gen_if: pixel input stream and 3x3 window output stream.
//   in_valid/in_ready/in_pixel   : raster-order pixel input
//   out_valid/out_ready          : window handshake
//   p0..p8                       : window, p0-p2 top row .. p6-p8 bottom row
//   out_last                     : final window of the frame
//   frame_done                   : one-cycle pulse after last pixel accepted
//   out_row/out_col              : window centre (only with WINGEN_POS_OUT_EN)
// Modports: slave = the generator, master = pixel source / window sink.
interface window_3x3_gen_if
    import wingen_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
`ifdef WINGEN_POS_OUT_EN
    ,
    parameter int ROW_W = row_width(IMG_H_DEF),
    parameter int COL_W = col_width(IMG_W_DEF)
`endif
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic             out_last;
    logic             frame_done;
`ifdef WINGEN_POS_OUT_EN
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
`endif

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
        output out_last, frame_done
`ifdef WINGEN_POS_OUT_EN
        , output out_row, out_col
`endif
    );

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
        input  out_last, frame_done
`ifdef WINGEN_POS_OUT_EN
        , input out_row, out_col
`endif
    );

endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// line_buffer: one-row delay line, DEPTH entries of WIDTH bits.
//   clk  : clock
//   en   : advance (pixel accepted this cycle)
//   addr : current column
//   din  : value written at addr when en
//   dout : value stored at addr before this cycle's write (one row ago)
// Contents are never cleared; the caller masks stale rows.
module line_buffer
    import wingen_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int WIDTH = PIX_W_DEF,
    parameter int AW    = col_width(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Read-before-write: the old entry is consumed in the same cycle the
    // new pixel replaces it, so the read must not see this cycle's write.
    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator.
//   clk, rst : clock, synchronous active-high reset
//   bus      : window_3x3_gen_if.slave (pixel in, window out)
// Each accepted pixel at row>=2, col>=2 yields one registered window whose
// bottom-right element p8 is that pixel. Two line buffers supply rows r-1
// and r-2. Optional macro WINGEN_POS_OUT_EN adds out_row/out_col carrying
// the window centre coordinate.
module window_3x3_gen
    import wingen_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    window_3x3_gen_if.slave bus
);
    localparam int COL_W = col_width(IMG_W);
    localparam int ROW_W = row_width(IMG_H);

    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    state_t           state_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic             frame_done_reg;

    logic             in_ready;
    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             frame_end;
    logic             emit;
    logic [PIX_W-1:0] lb0_out;
    logic [PIX_W-1:0] lb1_out;
    logic [PIX_W-1:0] new_col [3];
    logic [PIX_W-1:0] win [9];

    // Output register frees up whenever it is empty or being drained.
    assign in_ready  = !out_valid_reg || bus.out_ready;
    assign accept    = bus.in_valid && in_ready;
    assign col_last  = (col_reg == COL_W'(IMG_W - 1));
    assign row_last  = (row_reg == ROW_W'(IMG_H - 1));
    assign frame_end = col_last && row_last;
    assign emit      = accept && (state_reg == S_RUN) && (col_reg >= COL_W'(2));

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) lb0 (
        .clk  (clk),
        .en   (accept),
        .addr (col_reg),
        .din  (bus.in_pixel),
        .dout (lb0_out)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) lb1 (
        .clk  (clk),
        .en   (accept),
        .addr (col_reg),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    // Incoming right-hand column: top (r-2), middle (r-1), bottom (r).
    assign new_col[0] = lb1_out;
    assign new_col[1] = lb0_out;
    assign new_col[2] = bus.in_pixel;

    // One three-tap shift register per window row. Shifting on every accept
    // (not only emitting ones) keeps the columns c-2, c-1 primed.
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic [PIX_W-1:0] tap_reg [3];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < 3; k++) begin
                    tap_reg[k] <= '0;
                end
            end else if (accept) begin
                tap_reg[0] <= tap_reg[1];
                tap_reg[1] <= tap_reg[2];
                tap_reg[2] <= new_col[gi];
            end
        end

        assign win[3*gi + 0] = tap_reg[0];
        assign win[3*gi + 1] = tap_reg[1];
        assign win[3*gi + 2] = tap_reg[2];
    end

`ifdef WINGEN_POS_OUT_EN
    logic [ROW_W-1:0] out_row_reg;
    logic [COL_W-1:0] out_col_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg        <= '0;
            row_reg        <= '0;
            state_reg      <= S_FILL;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
`ifdef WINGEN_POS_OUT_EN
            out_row_reg    <= '0;
            out_col_reg    <= '0;
`endif
        end else begin
            frame_done_reg <= accept && frame_end;

            if (accept) begin
                if (col_last) begin
                    col_reg <= '0;
                    row_reg <= row_last ? '0 : row_reg + ROW_W'(1);
                end else begin
                    col_reg <= col_reg + COL_W'(1);
                end

                case (state_reg)
                    S_FILL:  if (col_last && row_reg == ROW_W'(1)) state_reg <= S_RUN;
                    S_RUN:   if (frame_end) state_reg <= S_FILL;
                    default: state_reg <= S_FILL;
                endcase
            end

            // A new window overwrites a draining one in the same cycle,
            // so back-to-back windows leave no bubble.
            if (emit) begin
                out_valid_reg <= 1'b1;
                out_last_reg  <= frame_end;
`ifdef WINGEN_POS_OUT_EN
                out_row_reg   <= row_reg - ROW_W'(1);
                out_col_reg   <= col_reg - COL_W'(1);
`endif
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_last   = out_last_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.p0 = win[0];
    assign bus.p1 = win[1];
    assign bus.p2 = win[2];
    assign bus.p3 = win[3];
    assign bus.p4 = win[4];
    assign bus.p5 = win[5];
    assign bus.p6 = win[6];
    assign bus.p7 = win[7];
    assign bus.p8 = win[8];
`ifdef WINGEN_POS_OUT_EN
    assign bus.out_row = out_row_reg;
    assign bus.out_col = out_col_reg;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;
    localparam int SW = 4;
    localparam int SH = 4;
    localparam int BW = 64;
    localparam int BH = 64;

    typedef struct packed {
        logic [8:0][12:0] p;
        logic             last;
        logic [31:0]      cyc;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   tmo = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    window_3x3_gen_if #(.PIX_W(13)
`ifdef WINGEN_POS_OUT_EN
        , .ROW_W(2), .COL_W(2)
`endif
    ) s_if ();
    window_3x3_gen_if #(.PIX_W(13)
`ifdef WINGEN_POS_OUT_EN
        , .ROW_W(6), .COL_W(6)
`endif
    ) b_if ();

    window_3x3_gen #(.IMG_W(SW), .IMG_H(SH), .PIX_W(13)) dut_s (.clk(clk), .rst(rst), .bus(s_if.slave));
    window_3x3_gen #(.IMG_W(BW), .IMG_H(BH), .PIX_W(13)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    // ---------------- reference models (one per instance) ----------------
    win_t        obs_s[$], exp_s[$], obs_b[$], exp_b[$];
    int          fdo_s[$], fde_s[$], fdo_b[$], fde_b[$];
    logic [12:0] img_s [SH][SW];
    logic [12:0] img_b [BH][BW];
    int          mr_s = 0, mc_s = 0, mr_b = 0, mc_b = 0;
    int          rdyv_s = 0, stabv_s = 0, rdyv_b = 0, stabv_b = 0;
    logic        stall_s = 1'b0, stall_b = 1'b0;
    logic [117:0] held_s, held_b;

    function automatic logic [117:0] swin();
        return {s_if.p8, s_if.p7, s_if.p6, s_if.p5, s_if.p4, s_if.p3, s_if.p2, s_if.p1, s_if.p0, s_if.out_last};
    endfunction
    function automatic logic [117:0] bwin();
        return {b_if.p8, b_if.p7, b_if.p6, b_if.p5, b_if.p4, b_if.p3, b_if.p2, b_if.p1, b_if.p0, b_if.out_last};
    endfunction

    always @(negedge clk) begin
        win_t w;
        if (rst) begin
            obs_s.delete(); exp_s.delete(); fdo_s.delete(); fde_s.delete();
            mr_s = 0; mc_s = 0; stall_s = 1'b0;
        end else begin
            if (s_if.out_valid && s_if.out_ready) begin
                w.p = {s_if.p8, s_if.p7, s_if.p6, s_if.p5, s_if.p4, s_if.p3, s_if.p2, s_if.p1, s_if.p0};
                w.last = s_if.out_last; w.cyc = cyc;
                obs_s.push_back(w);
            end
            if (s_if.frame_done) fdo_s.push_back(cyc);
            if (s_if.in_ready !== (!s_if.out_valid || s_if.out_ready)) rdyv_s++;
            if (stall_s && swin() !== held_s) stabv_s++;
            stall_s = s_if.out_valid && !s_if.out_ready;
            held_s  = swin();
            if (s_if.in_valid && s_if.in_ready) begin
                img_s[mr_s][mc_s] = s_if.in_pixel;
                if (mr_s >= 2 && mc_s >= 2) begin
                    for (int k = 0; k < 9; k++) w.p[k] = img_s[mr_s-2+k/3][mc_s-2+k%3];
                    w.last = (mr_s == SH-1) && (mc_s == SW-1); w.cyc = cyc + 1;
                    exp_s.push_back(w);
                end
                if (mr_s == SH-1 && mc_s == SW-1) fde_s.push_back(cyc + 1);
                mc_s++;
                if (mc_s == SW) begin mc_s = 0; mr_s = (mr_s == SH-1) ? 0 : mr_s + 1; end
            end
        end
    end

    always @(negedge clk) begin
        win_t w;
        if (rst) begin
            obs_b.delete(); exp_b.delete(); fdo_b.delete(); fde_b.delete();
            mr_b = 0; mc_b = 0; stall_b = 1'b0;
        end else begin
            if (b_if.out_valid && b_if.out_ready) begin
                w.p = {b_if.p8, b_if.p7, b_if.p6, b_if.p5, b_if.p4, b_if.p3, b_if.p2, b_if.p1, b_if.p0};
                w.last = b_if.out_last; w.cyc = cyc;
                obs_b.push_back(w);
            end
            if (b_if.frame_done) fdo_b.push_back(cyc);
            if (b_if.in_ready !== (!b_if.out_valid || b_if.out_ready)) rdyv_b++;
            if (stall_b && bwin() !== held_b) stabv_b++;
            stall_b = b_if.out_valid && !b_if.out_ready;
            held_b  = bwin();
            if (b_if.in_valid && b_if.in_ready) begin
                img_b[mr_b][mc_b] = b_if.in_pixel;
                if (mr_b >= 2 && mc_b >= 2) begin
                    for (int k = 0; k < 9; k++) w.p[k] = img_b[mr_b-2+k/3][mc_b-2+k%3];
                    w.last = (mr_b == BH-1) && (mc_b == BW-1); w.cyc = cyc + 1;
                    exp_b.push_back(w);
                end
                if (mr_b == BH-1 && mc_b == BW-1) fde_b.push_back(cyc + 1);
                mc_b++;
                if (mc_b == BW) begin mc_b = 0; mr_b = (mr_b == BH-1) ? 0 : mr_b + 1; end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_s(input logic [12:0] pix, input int vprob, input int rprob, output int acyc);
        logic acc, v, r;
        int   tries;
        acc = 1'b0; tries = 0; acyc = 0;
        while (!acc && tries < 1000) begin
            v = ($urandom_range(0, 99) < vprob);
            r = ($urandom_range(0, 99) < rprob);
            s_if.in_valid = v; s_if.in_pixel = pix; s_if.out_ready = r;
            @(negedge clk);
            acc = v && s_if.in_ready; acyc = cyc;
            @(posedge clk); #1;
            tries++;
        end
        if (!acc) tmo++;
    endtask

    task automatic send_b(input logic [12:0] pix, output int acyc);
        logic acc;
        int   tries;
        acc = 1'b0; tries = 0; acyc = 0;
        while (!acc && tries < 1000) begin
            b_if.in_valid = 1'b1; b_if.in_pixel = pix; b_if.out_ready = 1'b1;
            @(negedge clk);
            acc = b_if.in_ready; acyc = cyc;
            @(posedge clk); #1;
            tries++;
        end
        if (!acc) tmo++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_if.in_valid = 1'b0; s_if.out_ready = 1'b1;
            b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_s_out_valid: got %b expected 0", s_if.out_valid); end
        checks++; if (s_if.out_last !== 1'b0) begin errors++; $display("FAIL rst_s_out_last: got %b expected 0", s_if.out_last); end
        checks++; if (s_if.frame_done !== 1'b0) begin errors++; $display("FAIL rst_s_frame_done: got %b expected 0", s_if.frame_done); end
        checks++; if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL rst_s_in_ready: got %b expected 1", s_if.in_ready); end
        checks++; if (swin() !== '0) begin errors++; $display("FAIL rst_s_window: got %h expected 0", swin()); end
        checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_out_valid: got %b expected 0", b_if.out_valid); end
        checks++; if (b_if.frame_done !== 1'b0) begin errors++; $display("FAIL rst_b_frame_done: got %b expected 0", b_if.frame_done); end
        checks++; if (b_if.in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_in_ready: got %b expected 1", b_if.in_ready); end
        checks++; if (bwin() !== '0) begin errors++; $display("FAIL rst_b_window: got %h expected 0", bwin()); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // 4x4 ramp; vprob/rprob set in_valid / out_ready duty; nfr frames.
    task automatic test_small(input string name, input int vprob, input int rprob, input int nfr, input logic ramp);
        int eo, oo, fo, feo, rv, sv, acyc, c10, n, ne;
        int first_w [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int last_w  [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        logic [8:0][12:0] ref_w;
        logic [12:0] pix;
        eo = exp_s.size(); oo = obs_s.size(); fo = fdo_s.size(); feo = fde_s.size();
        rv = rdyv_s; sv = stabv_s; tmo = 0; c10 = 0;
        for (int i = 0; i < 16*nfr; i++) begin
            pix = ramp ? 13'(i % 16) : 13'($urandom_range(0, 8191));
            send_s(pix, vprob, rprob, acyc);
            if (i == 10) c10 = acyc;
        end
        idle(6);
        n = obs_s.size() - oo; ne = exp_s.size() - eo;
        checks++; if (n !== 4*nfr || ne !== 4*nfr) begin errors++; $display("FAIL %s_count: got %0d windows (model %0d), expected %0d", name, n, ne, 4*nfr); end
        for (int i = 0; i < ne; i++) begin
            checks++;
            if (i >= n) begin errors++; $display("FAIL %s_win[%0d]: got none expected %h", name, i, exp_s[eo+i].p); end
            else if ({obs_s[oo+i].p, obs_s[oo+i].last} !== {exp_s[eo+i].p, exp_s[eo+i].last})
                begin errors++; $display("FAIL %s_win[%0d]: got %h/%b expected %h/%b", name, i, obs_s[oo+i].p, obs_s[oo+i].last, exp_s[eo+i].p, exp_s[eo+i].last); end
        end
        if (ramp && n >= 4) begin
            for (int k = 0; k < 9; k++) ref_w[k] = 13'(first_w[k]);
            checks++; if (obs_s[oo].p !== ref_w) begin errors++; $display("FAIL %s_first: got %h expected %h", name, obs_s[oo].p, ref_w); end
            checks++; if (rprob == 100 && obs_s[oo].cyc !== 32'(c10 + 1)) begin errors++; $display("FAIL %s_latency: got cycle %0d expected %0d", name, obs_s[oo].cyc, c10 + 1); end
            for (int k = 0; k < 9; k++) ref_w[k] = 13'(last_w[k]);
            checks++; if ({obs_s[oo+3].p, obs_s[oo+3].last} !== {ref_w, 1'b1}) begin errors++; $display("FAIL %s_last: got %h/%b expected %h/1", name, obs_s[oo+3].p, obs_s[oo+3].last, ref_w); end
        end
        checks++;
        if (fdo_s.size() - fo !== nfr || fde_s.size() - feo !== nfr) begin errors++; $display("FAIL %s_frame_done: got %0d pulses expected %0d", name, fdo_s.size() - fo, nfr); end
        else for (int i = 0; i < nfr; i++) if (fdo_s[fo+i] !== fde_s[feo+i]) begin errors++; $display("FAIL %s_frame_done_cyc: got %0d expected %0d", name, fdo_s[fo+i], fde_s[feo+i]); end
        checks++; if (rdyv_s - rv !== 0 || stabv_s - sv !== 0) begin errors++; $display("FAIL %s_handshake: ready_rule_viol=%0d stall_change=%0d expected 0/0", name, rdyv_s - rv, stabv_s - sv); end
        checks++; if (tmo !== 0) begin errors++; $display("FAIL %s_timeout: got %0d stuck pixels expected 0", name, tmo); end
    endtask

    // One or more 64x64 frames; optional 5-cycle out_ready stall; random
    // or ramp pixels (ramp offset 1000 per frame plus base).
    task automatic test_big(input string name, input int nfr, input logic ramp, input int base, input logic stall);
        int eo, oo, fo, sv, acyc, c130, n, ne, nlast, stall_at;
        logic [12:0] pixq [$];
        logic [8:0][12:0] ref_w;
        logic [117:0] snap;
        eo = exp_b.size(); oo = obs_b.size(); fo = fdo_b.size(); sv = stabv_b; tmo = 0; c130 = 0;
        stall_at = 5*BW + 20;
        for (int i = 0; i < 4096*nfr; i++)
            pixq.push_back(ramp ? 13'(base + 1000*(i/4096) + (i%4096)) : 13'($urandom_range(0, 8191)));
        for (int i = 0; i < 4096*nfr; i++) begin
            send_b(pixq[i], acyc);
            if (i == 2*BW + 2) c130 = acyc;
            if (stall && i == stall_at) begin
                b_if.in_valid = 1'b1; b_if.in_pixel = pixq[i+1]; b_if.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    if (s == 0) snap = bwin();
                    else begin checks++; if (bwin() !== snap) begin errors++; $display("FAIL %s_stall_hold[%0d]: got %h expected %h", name, s, bwin(), snap); end end
                    checks++; if (b_if.in_ready !== 1'b0) begin errors++; $display("FAIL %s_stall_in_ready[%0d]: got %b expected 0", name, s, b_if.in_ready); end
                    checks++; if (b_if.out_valid !== 1'b1) begin errors++; $display("FAIL %s_stall_out_valid[%0d]: got %b expected 1", name, s, b_if.out_valid); end
                    @(posedge clk); #1;
                end
            end
        end
        idle(6);
        n = obs_b.size() - oo; ne = exp_b.size() - eo; nlast = 0;
        checks++; if (n !== 3844*nfr || ne !== 3844*nfr) begin errors++; $display("FAIL %s_count: got %0d windows (model %0d), expected %0d", name, n, ne, 3844*nfr); end
        for (int i = 0; i < ne; i++) begin
            checks++;
            if (i >= n) begin errors++; $display("FAIL %s_win[%0d]: got none expected %h", name, i, exp_b[eo+i].p); end
            else if ({obs_b[oo+i].p, obs_b[oo+i].last} !== {exp_b[eo+i].p, exp_b[eo+i].last})
                begin errors++; $display("FAIL %s_win[%0d]: got %h/%b expected %h/%b", name, i, obs_b[oo+i].p, obs_b[oo+i].last, exp_b[eo+i].p, exp_b[eo+i].last); end
            if (i < n && obs_b[oo+i].last) nlast++;
        end
        checks++; if (nlast !== nfr) begin errors++; $display("FAIL %s_out_last_count: got %0d expected %0d", name, nlast, nfr); end
        checks++; if (fdo_b.size() - fo !== nfr) begin errors++; $display("FAIL %s_frame_done: got %0d pulses expected %0d", name, fdo_b.size() - fo, nfr); end
        checks++; if (stabv_b - sv !== 0) begin errors++; $display("FAIL %s_stall_change: got %0d expected 0", name, stabv_b - sv); end
        checks++; if (tmo !== 0) begin errors++; $display("FAIL %s_timeout: got %0d stuck pixels expected 0", name, tmo); end
        if (ramp && n == 3844*nfr) begin
            for (int f = 0; f < nfr; f++) begin
                for (int k = 0; k < 9; k++) ref_w[k] = 13'(base + 1000*f + 64*(k/3) + k%3);
                checks++; if (obs_b[oo+3844*f].p !== ref_w) begin errors++; $display("FAIL %s_first[f%0d]: got %h expected %h", name, f, obs_b[oo+3844*f].p, ref_w); end
            end
            checks++; if (obs_b[oo].cyc !== 32'(c130 + 1)) begin errors++; $display("FAIL %s_latency: got cycle %0d expected %0d", name, obs_b[oo].cyc, c130 + 1); end
            checks++;
            if (obs_b[oo+n-1].p[0] !== 13'(base + 1000*(nfr-1) + 3965) || obs_b[oo+n-1].p[8] !== 13'(base + 1000*(nfr-1) + 4095) || obs_b[oo+n-1].last !== 1'b1)
                begin errors++; $display("FAIL %s_final: got p0=%0d p8=%0d last=%b expected p0=%0d p8=%0d last=1", name, obs_b[oo+n-1].p[0], obs_b[oo+n-1].p[8], obs_b[oo+n-1].last, base + 1000*(nfr-1) + 3965, base + 1000*(nfr-1) + 4095); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int acyc;
        for (int i = 0; i < 100; i++) send_b(13'(i), acyc);
        b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", b_if.out_valid); end
        checks++; if (b_if.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", b_if.in_ready); end
        @(posedge clk); #1;
        test_big("midrst_frame", 1, 1'b1, 2000, 1'b0);
    endtask

    initial begin
        s_if.in_valid = 1'b0; s_if.in_pixel = '0; s_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_pixel = '0; b_if.out_ready = 1'b1;
        test_reset();
        test_small("small_cont", 100, 100, 1, 1'b1);
        test_small("small_gaps", 50, 100, 1, 1'b1);
        test_small("small_rand", 70, 50, 2, 1'b0);
        test_big("full_frame", 1, 1'b1, 0, 1'b0);
        test_big("backpressure", 1, 1'b0, 0, 1'b1);
        test_reset_mid_frame();
        test_big("back_to_back", 2, 1'b1, 0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

endmodule
